// File: rtl/turret_angle_ctrl.sv
// Keyboard-driven turret elevation controller.
// Edge-detects UP/DOWN keycodes, steps a bounded (or wrapping) angle index,
// and auto-repeats a held key using an external frame tick for timing.
module turret_angle_ctrl #(
  parameter int unsigned N_STEPS      = 9,
  parameter int unsigned CENTER_IDX   = 4,
  parameter logic [7:0]  UP_KEY       = 8'h1A,
  parameter logic [7:0]  DOWN_KEY     = 8'h16,
  parameter bit          WRAP         = 1'b0,
  parameter int unsigned REPEAT_DELAY = 15,
  parameter int unsigned REPEAT_RATE  = 4,
  localparam int unsigned IW          = $clog2(N_STEPS)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic               tick,
  output logic [IW-1:0]      angle_idx,
  output logic [N_STEPS-1:0] angle_onehot,
  output logic               at_top,
  output logic               at_bottom,
  output logic               moved
);

  // Tick counter only has to reach max(REPEAT_DELAY, REPEAT_RATE) - 1.
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [IW-1:0]      TopIdx    = IW'(N_STEPS - 1);
  localparam logic [IW-1:0]      CenterIdx = IW'(CENTER_IDX);
  localparam logic [TW-1:0]      DelayLast = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]      RateLast  = TW'(REPEAT_RATE - 1);
  localparam logic [N_STEPS-1:0] CenterOh  = N_STEPS'(1) << CENTER_IDX;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [7:0]           prev_key_q;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_STEPS-1:0]   onehot_q, onehot_d;
  logic                 moved_q, moved_d;

  logic                 up, dn, held, press, step;

  // Key decode and press edge detection against last cycle's keycode.
  always_comb begin
    up    = (keycode == UP_KEY);
    dn    = (keycode == DOWN_KEY);
    held  = up | dn;
    press = held && (keycode != prev_key_q);
  end

  // Hold/repeat FSM: release beats press, press beats tick.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    step    = 1'b0;
    if (!held) begin
      state_d = StIdle;
      tcnt_d  = '0;
    end else if (press) begin
      // A fresh press (including a direct direction switch) restarts the delay.
      step    = 1'b1;
      tcnt_d  = '0;
      state_d = StDelay;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StDelay: begin
          if (tcnt_q == DelayLast) begin
            step    = 1'b1;
            tcnt_d  = '0;
            state_d = StRepeat;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        StRepeat: begin
          if (tcnt_q == RateLast) begin
            step   = 1'b1;
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  // Next angle: step up/down with saturate or wrap at the ends.
  always_comb begin
    idx_d = idx_q;
    if (step) begin
      if (up) begin
        if (idx_q == TopIdx) begin
          idx_d = WRAP ? '0 : idx_q;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d = WRAP ? TopIdx : idx_q;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
    end
    moved_d = (idx_d != idx_q);
    for (int i = 0; i < int'(N_STEPS); i++) begin
      onehot_d[i] = (idx_d == IW'(i));
    end
  end

  // State, counter, key history and angle registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StIdle;
      tcnt_q     <= '0;
      prev_key_q <= 8'h00;
      idx_q      <= CenterIdx;
      onehot_q   <= CenterOh;
      moved_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      prev_key_q <= keycode;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      moved_q    <= moved_d;
    end
  end

  // End-stop flags decoded from the registered index.
  always_comb begin
    angle_idx    = idx_q;
    angle_onehot = onehot_q;
    moved        = moved_q;
    at_top       = (idx_q == TopIdx);
    at_bottom    = (idx_q == '0);
  end

endmodule

// File: tb/tb_turret_angle_ctrl.sv
// Randomized bench for turret_angle_ctrl: a saturating and a wrapping instance
// share one stimulus stream and are checked every cycle against a tick-count model.
module tb_turret_angle_ctrl;

  localparam int NS = 9;
  localparam int CI = 4;
  localparam int RD = 3;
  localparam int RR = 2;
  localparam logic [7:0] KUP = 8'h1A;
  localparam logic [7:0] KDN = 8'h16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic          tick;

  logic [3:0]    idx_s, idx_w;
  logic [NS-1:0] oh_s, oh_w;
  logic          top_s, top_w, bot_s, bot_w, mv_s, mv_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: angle per instance, plus ticks counted since the last press.
  int         m_idx [2];
  bit         m_moved [2];
  logic [7:0] m_prev;
  int         m_ticks;

  always #5 Clk = ~Clk;

  turret_angle_ctrl #(
    .N_STEPS(NS), .CENTER_IDX(CI), .UP_KEY(KUP), .DOWN_KEY(KDN),
    .WRAP(1'b0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_sat (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .tick(tick),
    .angle_idx(idx_s), .angle_onehot(oh_s), .at_top(top_s), .at_bottom(bot_s), .moved(mv_s)
  );

  turret_angle_ctrl #(
    .N_STEPS(NS), .CENTER_IDX(CI), .UP_KEY(KUP), .DOWN_KEY(KDN),
    .WRAP(1'b1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_wrap (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .tick(tick),
    .angle_idx(idx_w), .angle_onehot(oh_w), .at_top(top_w), .at_bottom(bot_w), .moved(mv_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step(input bit rst_n, input logic [7:0] key, input bit tk);
    bit stp;
    bit is_up;
    int nxt;
    stp   = 1'b0;
    is_up = (key == KUP);
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        m_idx[w]   = CI;
        m_moved[w] = 1'b0;
      end
      m_prev  = 8'h00;
      m_ticks = 0;
      return;
    end
    if (key != KUP && key != KDN) begin
      m_ticks = 0;
    end else if (key != m_prev) begin
      stp     = 1'b1;
      m_ticks = 0;
    end else if (tk) begin
      m_ticks++;
      // First repeat after RD ticks, then every RR ticks.
      if (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RR == 0)) stp = 1'b1;
    end
    m_prev = key;
    for (int w = 0; w < 2; w++) begin
      m_moved[w] = 1'b0;
      if (stp) begin
        nxt = m_idx[w] + (is_up ? 1 : -1);
        if (w == 1) nxt = (nxt + NS) % NS;
        else if (nxt < 0) nxt = 0;
        else if (nxt > NS - 1) nxt = NS - 1;
        if (nxt != m_idx[w]) begin
          m_moved[w] = 1'b1;
          m_idx[w]   = nxt;
        end
      end
    end
  endtask

  task automatic do_cycle(input bit rst_n, input logic [7:0] key, input bit tk);
    Reset   = rst_n;
    keycode = key;
    tick    = tk;
    model_step(rst_n, key, tk);
    @(posedge Clk);
    #1;
    check_eq("sat_idx",    32'(idx_s), 32'(m_idx[0]));
    check_eq("sat_onehot", 32'(oh_s),  32'(1) << m_idx[0]);
    check_eq("sat_moved",  32'(mv_s),  32'(m_moved[0]));
    check_eq("sat_top",    32'(top_s), 32'(m_idx[0] == NS - 1));
    check_eq("sat_bottom", 32'(bot_s), 32'(m_idx[0] == 0));
    check_eq("wrap_idx",    32'(idx_w), 32'(m_idx[1]));
    check_eq("wrap_onehot", 32'(oh_w),  32'(1) << m_idx[1]);
    check_eq("wrap_moved",  32'(mv_w),  32'(m_moved[1]));
    check_eq("wrap_top",    32'(top_w), 32'(m_idx[1] == NS - 1));
    check_eq("wrap_bottom", 32'(bot_w), 32'(m_idx[1] == 0));
  endtask

  task automatic reset2();
    do_cycle(1'b0, 8'h00, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] k;
    bit         tk;
    int         len;

    Reset = 1'b0; keycode = 8'h00; tick = 1'b0;

    // Reset values against fixed constants.
    reset2();
    check_eq("rst_idx", 32'(idx_s), 32'd4);
    check_eq("rst_onehot", 32'(oh_s), 32'h010);
    check_eq("rst_moved", 32'(mv_s), 32'd0);
    check_eq("rst_topbot", 32'({top_s, bot_s}), 32'd0);

    // Single tap up: one step, one moved pulse.
    do_cycle(1'b1, KUP, 1'b0);
    check_eq("tap_idx", 32'(idx_s), 32'd5);
    check_eq("tap_moved", 32'(mv_s), 32'd1);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'h00, 1'b0);
    check_eq("tap_settle", 32'(idx_s), 32'd5);

    // Hold up with a tick every 10 cycles: climbs to the top then sits there.
    reset2();
    for (int i = 0; i < 100; i++) do_cycle(1'b1, KUP, (i % 10) == 9);
    check_eq("hold_top_idx", 32'(idx_s), 32'd8);
    check_eq("hold_at_top", 32'(top_s), 32'd1);
    do_cycle(1'b1, 8'h00, 1'b0);

    // Walk to the bottom by taps, then tap down once more.
    reset2();
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, KDN, 1'b0);
      do_cycle(1'b1, 8'h00, 1'b0);
    end
    do_cycle(1'b1, KDN, 1'b0);
    check_eq("wrap_under_idx", 32'(idx_w), 32'd8);
    check_eq("wrap_under_onehot", 32'(oh_w), 32'h100);
    check_eq("wrap_under_moved", 32'(mv_w), 32'd1);
    check_eq("sat_under_idx", 32'(idx_s), 32'd0);
    check_eq("sat_under_moved", 32'(mv_s), 32'd0);
    do_cycle(1'b1, 8'h00, 1'b0);

    // Hold up into repeat, then switch straight to down and keep holding.
    reset2();
    for (int i = 0; i < 20; i++) do_cycle(1'b1, KUP, (i % 3) == 2);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, KDN, (i % 3) == 2);

    // Reset mid-repeat with the key held throughout.
    for (int i = 0; i < 20; i++) do_cycle(1'b1, KUP, (i % 3) == 2);
    do_cycle(1'b0, KUP, 1'b0);
    do_cycle(1'b0, KUP, 1'b0);
    check_eq("midrst_idx", 32'(idx_s), 32'd4);
    do_cycle(1'b1, KUP, 1'b0);
    check_eq("midrst_step", 32'(idx_s), 32'd5);
    do_cycle(1'b1, 8'h00, 1'b0);

    // Random segments of held keys with random ticks and occasional reset.
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 4))
        0, 1:    k = KUP;
        2:       k = KDN;
        3:       k = 8'h00;
        default: k = 8'($urandom);
      endcase
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        tk = ($urandom_range(0, 3) == 0);
        do_cycle(($urandom_range(0, 60) != 0), k, tk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
